// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline memory arbiter and hazard control.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IFETCH,
        DATA,
        DRAIN
    } arb_state_t;

    localparam logic [3:0] WSTRB_ALL = 4'hF;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/arb_streak_ctr.sv
// Counts consecutive data grants made while IF is waiting; flags when IF must
// be let through. Only instantiated when MEMARB_STARVE_GUARD_EN is defined.
module arb_streak_ctr #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit
);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 4'd0;
        end else if (inc && count != 4'hF) begin
            count <= count + 4'd1;
        end
    end

    assign limit = (count >= 4'(MAX_DSTREAK));

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates the single unified memory bus between IF fetches and MEM loads/stores.
// Optional IF starvation guard: define MEMARB_STARVE_GUARD_EN.
module pipe_mem_arbiter
    import pipe_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              flush,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_t state, next_state;
    logic       grant_if, grant_d, starve;

`ifdef MEMARB_STARVE_GUARD_EN
    arb_streak_ctr #(.MAX_DSTREAK(MAX_DSTREAK)) u_streak (
        .clk  (clk),
        .rst  (rst),
        .inc  (grant_d && if_req),
        .clr  (grant_if),
        .limit(starve)
    );
`else
    logic unused_streak_cfg;
    assign unused_streak_cfg = ^4'(MAX_DSTREAK);
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A valid pulse means the requester has not yet updated its request, so
    // that IDLE cycle never grants; this also enforces the gap between issues.
    always_comb begin
        // NOTE: defaults first, so no path through the block leaves a
        // variable unassigned and infers a latch.
        next_state = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (!(if_valid || d_valid)) begin
                    if (starve && if_req && !flush) grant_if = 1'b1;
                    else if (d_rd || d_wr)          grant_d  = 1'b1;
                    else if (if_req && !flush)      grant_if = 1'b1;
                end
                if (grant_d)       next_state = DATA;
                else if (grant_if) next_state = IFETCH;
            end
            IFETCH: begin
                if (bus_ready)  next_state = IDLE;
                else if (flush) next_state = DRAIN;
            end
            DATA:    if (bus_ready) next_state = IDLE;
            DRAIN:   if (bus_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus_req  = (state != IDLE);
        if_stall = if_req & ~if_valid;
        d_stall  = (d_rd | d_wr) & ~d_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= 4'h0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (grant_d) begin
                bus_addr  <= d_addr;
                bus_we    <= d_wr;
                bus_wdata <= d_wdata;
                bus_wstrb <= d_wr ? d_wstrb : WSTRB_ALL;
            end else if (grant_if) begin
                bus_addr  <= if_addr;
                bus_we    <= 1'b0;
                bus_wstrb <= WSTRB_ALL;
            end
            if (state == IFETCH && bus_ready && !flush) begin
                if_rdata <= bus_rdata;
                if_valid <= 1'b1;
            end
            if (state == DATA && bus_ready) begin
                d_valid <= 1'b1;
                if (!bus_we) d_rdata <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: fetch, collision, store, flush, reset,
// and (with MEMARB_STARVE_GUARD_EN) the starvation-guard grant order.
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        flush;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    pipe_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MAX_DSTREAK(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_stall (if_stall),
        .flush    (flush),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .d_stall  (d_stall),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = 4'h0;
        bus_ready = 1'b0; bus_rdata = '0;
        tick(); tick();

        // Reset state
        check("rst_bus_req",   {31'd0, bus_req},  32'd0);
        check("rst_if_valid",  {31'd0, if_valid}, 32'd0);
        check("rst_d_valid",   {31'd0, d_valid},  32'd0);
        check("rst_bus_addr",  bus_addr,          32'd0);
        check("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        check("rst_if_rdata",  if_rdata,          32'd0);

        // Fetch only
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("f_stall_pre",   {31'd0, if_stall}, 32'd1);
        check("f_req_pre",     {31'd0, bus_req},  32'd0);
        tick();
        check("f_bus_req",     {31'd0, bus_req},  32'd1);
        check("f_bus_addr",    bus_addr,          32'h100);
        check("f_bus_we",      {31'd0, bus_we},   32'd0);
        check("f_bus_wstrb",   {28'd0, bus_wstrb}, 32'hF);
        tick();
        check("f_req_held",    {31'd0, bus_req},  32'd1);
        check("f_stall_wait",  {31'd0, if_stall}, 32'd1);
        bus_ready = 1'b1; bus_rdata = 32'h00A00093;
        tick();
        bus_ready = 1'b0;
        check("f_if_valid",    {31'd0, if_valid}, 32'd1);
        check("f_if_rdata",    if_rdata,          32'h00A00093);
        check("f_stall_done",  {31'd0, if_stall}, 32'd0);
        check("f_req_done",    {31'd0, bus_req},  32'd0);
        if_req = 1'b0;
        tick();
        check("f_valid_pulse", {31'd0, if_valid}, 32'd0);

        // Collision: data wins, then IF
        if_req = 1'b1; if_addr = 32'h104; d_rd = 1'b1; d_addr = 32'h2000;
        tick();
        check("c_addr_data",   bus_addr,          32'h2000);
        check("c_we_load",     {31'd0, bus_we},   32'd0);
        check("c_d_stall",     {31'd0, d_stall},  32'd1);
        check("c_if_stall",    {31'd0, if_stall}, 32'd1);
        tick();
        bus_ready = 1'b1; bus_rdata = 32'h11223344;
        tick();
        bus_ready = 1'b0;
        check("c_d_valid",     {31'd0, d_valid},  32'd1);
        check("c_d_rdata",     d_rdata,           32'h11223344);
        check("c_if_valid_no", {31'd0, if_valid}, 32'd0);
        check("c_gap_idle",    {31'd0, bus_req},  32'd0);
        d_rd = 1'b0;
        tick();
        check("c_d_valid_end", {31'd0, d_valid},  32'd0);
        check("c_gap_idle2",   {31'd0, bus_req},  32'd0);
        tick();
        check("c_if_grant",    {31'd0, bus_req},  32'd1);
        check("c_addr_pc",     bus_addr,          32'h104);
        tick();
        bus_ready = 1'b1; bus_rdata = 32'h0040006F;
        tick();
        bus_ready = 1'b0;
        check("c_if_valid",    {31'd0, if_valid}, 32'd1);
        check("c_if_rdata",    if_rdata,          32'h0040006F);
        if_req = 1'b0;
        tick();

        // Store
        d_wr = 1'b1; d_addr = 32'h3004; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        tick();
        check("s_bus_we",      {31'd0, bus_we},   32'd1);
        check("s_bus_wstrb",   {28'd0, bus_wstrb}, 32'h3);
        check("s_bus_wdata",   bus_wdata,         32'hDEADBEEF);
        check("s_bus_addr",    bus_addr,          32'h3004);
        tick();
        bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ready = 1'b0;
        check("s_d_valid",     {31'd0, d_valid},  32'd1);
        check("s_d_rdata",     d_rdata,           32'h11223344);
        d_wr = 1'b0;
        tick();
        check("s_valid_pulse", {31'd0, d_valid},  32'd0);

        // Flush mid-fetch: DRAIN holds bus_req until bus_ready
        if_req = 1'b1; if_addr = 32'h200;
        tick();
        check("fl_grant",      {31'd0, bus_req},  32'd1);
        tick();
        flush = 1'b1; if_req = 1'b0;
        tick();
        flush = 1'b0;
        check("fl_drain_req",  {31'd0, bus_req},  32'd1);
        check("fl_drain_addr", bus_addr,          32'h200);
        tick();
        check("fl_drain_req2", {31'd0, bus_req},  32'd1);
        check("fl_no_valid",   {31'd0, if_valid}, 32'd0);
        bus_ready = 1'b1; bus_rdata = 32'hBAD0BAD0;
        tick();
        bus_ready = 1'b0;
        check("fl_idle",       {31'd0, bus_req},  32'd0);
        check("fl_no_valid2",  {31'd0, if_valid}, 32'd0);
        check("fl_rdata_kept", if_rdata,          32'h0040006F);
        tick();

        // Flush coinciding with bus_ready: no if_valid
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        tick();
        bus_ready = 1'b1; flush = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_ready = 1'b0; flush = 1'b0; if_req = 1'b0;
        check("fr_no_valid",   {31'd0, if_valid}, 32'd0);
        check("fr_idle",       {31'd0, bus_req},  32'd0);
        check("fr_rdata_kept", if_rdata,          32'h0040006F);
        tick();

        // Synchronous reset during DATA
        d_rd = 1'b1; d_addr = 32'h4000;
        tick();
        check("r_req_before",  {31'd0, bus_req},  32'd1);
        rst = 1'b1;
        tick();
        check("r_req_cleared", {31'd0, bus_req},  32'd0);
        check("r_d_valid",     {31'd0, d_valid},  32'd0);
        check("r_bus_addr",    bus_addr,          32'd0);
        rst = 1'b0; d_rd = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ready = 1'b0;
        check("r_late_ready",  {31'd0, d_valid},  32'd0);
        check("r_late_ifv",    {31'd0, if_valid}, 32'd0);
        check("r_late_idle",   {31'd0, bus_req},  32'd0);
        tick();
        check("r_late_ready2", {31'd0, d_valid},  32'd0);

`ifdef MEMARB_STARVE_GUARD_EN
        // Starvation guard with MAX_DSTREAK=2: D, D, IF, D, D, IF
        begin
            logic [31:0] exp_order [6];
            exp_order[0] = 32'h5000; exp_order[1] = 32'h5000; exp_order[2] = 32'h600;
            exp_order[3] = 32'h5000; exp_order[4] = 32'h5000; exp_order[5] = 32'h600;
            d_rd = 1'b1; d_addr = 32'h5000; if_req = 1'b1; if_addr = 32'h600;
            for (int i = 0; i < 6; i++) begin
                int n = 0;
                while (!bus_req && n < 10) begin
                    tick();
                    n++;
                end
                check("sg_grant_seen", {31'd0, bus_req}, 32'd1);
                check("sg_grant_addr", bus_addr, exp_order[i]);
                tick();
                bus_ready = 1'b1; bus_rdata = 32'h0;
                tick();
                bus_ready = 1'b0;
            end
            d_rd = 1'b0; if_req = 1'b0;
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
